// File: rtl/cart_mapper.sv
// -----------------------------------------------------------------------------
// cart_mapper
//   Cartridge bank-switch controller between the 6502 address bus and the
//   cartridge ROM / Superchip RAM. It snoops every CPU access, updates bank
//   registers when a hotspot is touched, and translates the 13-bit CPU address
//   into a ROM address of up to 32 KB.
//
// Parameters
//   ROM_ADDR_BITS : width of rom_adr_o (image size = 2**ROM_ADDR_BITS bytes)
//   SC_ENABLE     : 1 builds the Superchip window decode, 0 ties sc_* low
//
// Ports
//   clk_i      system clock
//   rst_i      synchronous active-high reset (wins over enable_i)
//   enable_i   one-clk strobe per CPU cycle; qualifies every register update
//   adr_i      CPU address bus (only [12:0] are decoded, 8K cart mirror)
//   we_i       CPU write (active high)
//   dat_i      CPU write data (3F snoops the low nibble)
//   mapper_i   0 none, 1 F8, 2 F6, 3 F4, 4 E0, 5 3F, 6/7 behave as none
//   sc_en_i    Superchip RAM present (honoured for F8/F6/F4 only)
//   rom_adr_o  translated ROM address (combinational)
//   sc_rd_o    CPU reads the Superchip read window
//   sc_we_o    Superchip RAM write strobe
//   sc_adr_o   Superchip RAM address (adr_i[6:0])
//   bank_o     current bank (F-type / 3F) or E0 slice-0 bank
//
// CPU-cycle handshake: there is no back-pressure. enable_i is the only
// transfer qualifier; a register update happens on a rising clk_i edge
// exactly when enable_i is high and rst_i is low. Address/data/we are only
// meaningful while enable_i is high; the combinational outputs simply track
// the bus so the top-level data mux sees them throughout the CPU cycle.
// -----------------------------------------------------------------------------
module cart_mapper #(
  parameter int ROM_ADDR_BITS = 15,
  parameter bit SC_ENABLE     = 1'b1
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic                     enable_i,
  input  logic [15:0]              adr_i,
  input  logic                     we_i,
  input  logic [7:0]               dat_i,
  input  logic [2:0]               mapper_i,
  input  logic                     sc_en_i,
  output logic [ROM_ADDR_BITS-1:0] rom_adr_o,
  output logic                     sc_rd_o,
  output logic                     sc_we_o,
  output logic [6:0]               sc_adr_o,
  output logic [3:0]               bank_o
);

  typedef enum logic [2:0] {
    MAP_NONE = 3'd0,
    MAP_F8   = 3'd1,
    MAP_F6   = 3'd2,
    MAP_F4   = 3'd3,
    MAP_E0   = 3'd4,
    MAP_3F   = 3'd5
  } mapper_t;

  // Translation is built in a word at least 16 bits wide and then truncated,
  // so any ROM_ADDR_BITS from a small 2K image up to the full 32K works.
  localparam int FULL_W = (ROM_ADDR_BITS > 16) ? ROM_ADDR_BITS : 16;

  // ---------------------------------------------------------------------------
  // Scheme decode: the two unassigned encodings fall back to "none".
  // ---------------------------------------------------------------------------
  mapper_t scheme;

  always_comb begin
    scheme = MAP_NONE;
    case (mapper_i)
      3'd1:    scheme = MAP_F8;
      3'd2:    scheme = MAP_F6;
      3'd3:    scheme = MAP_F4;
      3'd4:    scheme = MAP_E0;
      3'd5:    scheme = MAP_3F;
      default: scheme = MAP_NONE;
    endcase
  end

  logic        is_ftype;
  logic [11:0] offset;
  logic        cart_sel;

  assign is_ftype = (scheme == MAP_F8) || (scheme == MAP_F6) || (scheme == MAP_F4);
  assign offset   = adr_i[11:0];
  assign cart_sel = adr_i[12];

  // ---------------------------------------------------------------------------
  // Bank registers
  // ---------------------------------------------------------------------------
  logic [2:0] bank,   bank_nxt;
  logic [2:0] e0_s0,  e0_s0_nxt;
  logic [2:0] e0_s1,  e0_s1_nxt;
  logic [2:0] e0_s2,  e0_s2_nxt;
  logic [3:0] bank3f, bank3f_nxt;
  logic [2:0] bank_rst;

  // F-type carts power up in their last bank, where the reset vector lives.
  always_comb begin
    bank_rst = 3'd0;
    case (scheme)
      MAP_F8:  bank_rst = 3'd1;
      MAP_F6:  bank_rst = 3'd3;
      MAP_F4:  bank_rst = 3'd7;
      default: bank_rst = 3'd0;
    endcase
  end

  // Hotspot decode. Reads and writes both trigger. Because the registers only
  // load at the clock edge that closes the CPU cycle, the byte fetched during
  // the hotspot cycle still comes from the old bank. Holding the address over
  // several strobes (CPU stall) just reloads the same value.
  always_comb begin
    bank_nxt   = bank;
    e0_s0_nxt  = e0_s0;
    e0_s1_nxt  = e0_s1;
    e0_s2_nxt  = e0_s2;
    bank3f_nxt = bank3f;

    if (enable_i && cart_sel) begin
      case (scheme)
        MAP_F8: begin
          if (offset == 12'hFF8 || offset == 12'hFF9)
            bank_nxt = 3'(offset - 12'hFF8);
        end
        MAP_F6: begin
          if (offset >= 12'hFF6 && offset <= 12'hFF9)
            bank_nxt = 3'(offset - 12'hFF6);
        end
        MAP_F4: begin
          if (offset >= 12'hFF4 && offset <= 12'hFFB)
            bank_nxt = 3'(offset - 12'hFF4);
        end
        MAP_E0: begin
          // FE0-FE7 / FE8-FEF / FF0-FF7 select slices 0/1/2; the low three
          // offset bits are the new bank for that slice.
          case (offset[11:3])
            9'h1FC:  e0_s0_nxt = offset[2:0];
            9'h1FD:  e0_s1_nxt = offset[2:0];
            9'h1FE:  e0_s2_nxt = offset[2:0];
            default: ;
          endcase
        end
        default: ;
      endcase
    end

    // 3F latches on any write to $0000-$003F (TIA space). The TIA still sees
    // the write; this is a pure snoop.
    if (enable_i && we_i && scheme == MAP_3F && adr_i[12:6] == 7'd0)
      bank3f_nxt = dat_i[3:0];
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      bank   <= bank_rst;
      e0_s0  <= 3'd0;
      e0_s1  <= 3'd1;
      e0_s2  <= 3'd2;
      bank3f <= 4'd0;
    end else begin
      bank   <= bank_nxt;
      e0_s0  <= e0_s0_nxt;
      e0_s1  <= e0_s1_nxt;
      e0_s2  <= e0_s2_nxt;
      bank3f <= bank3f_nxt;
    end
  end

  // ---------------------------------------------------------------------------
  // Address translation (same formula whatever adr_i[12] is)
  // ---------------------------------------------------------------------------
  logic [2:0]        slice_bank;
  logic [FULL_W-1:0] full_adr;

  // E0: 1 KB slice selected by adr_i[11:10]; slice 3 is hard-wired to bank 7.
  always_comb begin
    slice_bank = 3'd7;
    case (adr_i[11:10])
      2'd0:    slice_bank = e0_s0;
      2'd1:    slice_bank = e0_s1;
      2'd2:    slice_bank = e0_s2;
      default: slice_bank = 3'd7;
    endcase
  end

  always_comb begin
    full_adr = '0;
    case (scheme)
      MAP_F8, MAP_F6, MAP_F4: full_adr[14:0] = {bank, adr_i[11:0]};
      MAP_E0:                 full_adr[12:0] = {slice_bank, adr_i[9:0]};
      MAP_3F: begin
        // Upper 2 KB is fixed to the last 2K bank of the image.
        if (adr_i[11])
          full_adr[14:0] = {4'hF, adr_i[10:0]};
        else
          full_adr[14:0] = {bank3f, adr_i[10:0]};
      end
      default:                full_adr[11:0] = adr_i[11:0];
    endcase
  end

  assign rom_adr_o = full_adr[ROM_ADDR_BITS-1:0];

  // ---------------------------------------------------------------------------
  // Diagnostics bank view
  // ---------------------------------------------------------------------------
  always_comb begin
    bank_o = 4'd0;
    case (scheme)
      MAP_F8, MAP_F6, MAP_F4: bank_o = {1'b0, bank};
      MAP_E0:                 bank_o = {1'b0, e0_s0};
      MAP_3F:                 bank_o = bank3f;
      default:                bank_o = 4'd0;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Superchip windows: $1000-$107F write port, $1080-$10FF read port.
  // A write into the read window or a read of the write window is left to
  // ROM, so the two outputs can never be high together.
  // ---------------------------------------------------------------------------
  generate
    if (SC_ENABLE) begin : g_sc
      logic sc_active;
      logic wr_win;
      logic rd_win;

      assign sc_active = sc_en_i && is_ftype;
      assign wr_win    = cart_sel && (adr_i[11:7] == 5'd0);
      assign rd_win    = cart_sel && (adr_i[11:7] == 5'd1);

      assign sc_we_o   = sc_active && wr_win && we_i;
      assign sc_rd_o   = sc_active && rd_win && !we_i;
      assign sc_adr_o  = adr_i[6:0];
    end else begin : g_no_sc
      logic unused_sc;
      assign unused_sc = &{1'b0, sc_en_i, is_ftype};
      assign sc_we_o   = 1'b0;
      assign sc_rd_o   = 1'b0;
      assign sc_adr_o  = 7'd0;
    end
  endgenerate

  // Bits the cart never decodes (6502 A13-A15 are not on the cart port; 3F
  // only keeps the low nibble of the data).
  logic unused_bits;
  assign unused_bits = &{1'b0, adr_i[15:13], dat_i[7:4]};

endmodule

// File: tb/tb_cart_mapper.sv
// -----------------------------------------------------------------------------
// tb_cart_mapper
//   Directed bench for cart_mapper (ROM_ADDR_BITS = 15, SC_ENABLE = 1).
//   Expected values are hand-computed from the bank-switch rules.
// -----------------------------------------------------------------------------
module tb_cart_mapper;

  logic        clk_i;
  logic        rst_i;
  logic        enable_i;
  logic [15:0] adr_i;
  logic        we_i;
  logic [7:0]  dat_i;
  logic [2:0]  mapper_i;
  logic        sc_en_i;
  logic [14:0] rom_adr_o;
  logic        sc_rd_o;
  logic        sc_we_o;
  logic [6:0]  sc_adr_o;
  logic [3:0]  bank_o;

  int total = 0;
  int bad   = 0;

  cart_mapper #(
    .ROM_ADDR_BITS(15),
    .SC_ENABLE    (1'b1)
  ) dut (
    .clk_i    (clk_i),
    .rst_i    (rst_i),
    .enable_i (enable_i),
    .adr_i    (adr_i),
    .we_i     (we_i),
    .dat_i    (dat_i),
    .mapper_i (mapper_i),
    .sc_en_i  (sc_en_i),
    .rom_adr_o(rom_adr_o),
    .sc_rd_o  (sc_rd_o),
    .sc_we_o  (sc_we_o),
    .sc_adr_o (sc_adr_o),
    .bank_o   (bank_o)
  );

  // ---------------------------------------------------------------------------
  // Clock
  // ---------------------------------------------------------------------------
  initial clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  // ---------------------------------------------------------------------------
  // Driver tasks
  // ---------------------------------------------------------------------------
  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  // Place a bus cycle on the inputs; combinational outputs settle after #1.
  task automatic bus(input logic [15:0] a, input logic w, input logic [7:0] d,
                     input logic en);
    adr_i    = a;
    we_i     = w;
    dat_i    = d;
    enable_i = en;
    #1;
  endtask

  // One complete CPU cycle (strobe high for one clock), bus returned idle.
  task automatic cpu(input logic [15:0] a, input logic w, input logic [7:0] d);
    bus(a, w, d, 1'b1);
    tick();
    enable_i = 1'b0;
  endtask

  task automatic do_reset(input logic [2:0] m);
    mapper_i = m;
    rst_i    = 1'b1;
    bus(16'h0000, 1'b0, 8'h00, 1'b0);
    tick();
    tick();
    rst_i = 1'b0;
  endtask

  // ---------------------------------------------------------------------------
  // Checker
  // ---------------------------------------------------------------------------
  task automatic check(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // ---------------------------------------------------------------------------
  // Directed sequence
  // ---------------------------------------------------------------------------
  initial begin
    rst_i    = 1'b1;
    enable_i = 1'b0;
    adr_i    = 16'h0000;
    we_i     = 1'b0;
    dat_i    = 8'h00;
    mapper_i = 3'd1;
    sc_en_i  = 1'b0;

    // ---------------- F8 ----------------
    do_reset(3'd1);
    check("f8_rst_bank", bank_o, 4'd1);
    check("f8_rst_sc_rd", sc_rd_o, 1'b0);
    check("f8_rst_sc_we", sc_we_o, 1'b0);
    check("f8_rst_sc_adr", sc_adr_o, 7'd0);

    bus(16'h1FF8, 1'b0, 8'h00, 1'b1);
    check("f8_hot_old_bank", rom_adr_o, 15'h1FF8);
    tick();
    enable_i = 1'b0;
    bus(16'h1000, 1'b0, 8'h00, 1'b0);
    check("f8_bank0_adr", rom_adr_o, 15'h0000);
    check("f8_bank0", bank_o, 4'd0);

    cpu(16'h1FF9, 1'b0, 8'h00);
    bus(16'h1000, 1'b0, 8'h00, 1'b0);
    check("f8_bank1_adr", rom_adr_o, 15'h1000);

    // Stalled CPU: same hotspot held across three strobes.
    bus(16'h1FF8, 1'b0, 8'h00, 1'b1);
    tick();
    tick();
    tick();
    enable_i = 1'b0;
    check("f8_stall_idem", bank_o, 4'd0);

    // ---------------- F4 ----------------
    do_reset(3'd3);
    check("f4_rst_bank", bank_o, 4'd7);
    for (int i = 0; i < 8; i++) begin
      cpu(16'h1FF4 + 16'(i), 1'b0, 8'h00);
      check($sformatf("f4_sweep_%0d", i), bank_o, 4'(i));
    end
    bus(16'h1123, 1'b0, 8'h00, 1'b0);
    check("f4_bank7_adr", rom_adr_o, 15'h7123);

    bus(16'h1FF4, 1'b0, 8'h00, 1'b0);
    tick();
    check("f4_no_enable", bank_o, 4'd7);

    cpu(16'h1500, 1'b1, 8'hA5);
    check("f4_plain_write", bank_o, 4'd7);
    cpu(16'h1FF3, 1'b0, 8'h00);
    check("f4_below_hot", bank_o, 4'd7);

    // ---------------- E0 ----------------
    do_reset(3'd4);
    check("e0_rst_bank", bank_o, 4'd0);
    bus(16'h1410, 1'b0, 8'h00, 1'b0);
    check("e0_rst_s1", rom_adr_o, 15'h0410);
    bus(16'h1810, 1'b0, 8'h00, 1'b0);
    check("e0_rst_s2", rom_adr_o, 15'h0810);

    cpu(16'h1FE5, 1'b0, 8'h00);
    cpu(16'h1FEB, 1'b0, 8'h00);
    cpu(16'h1FF2, 1'b0, 8'h00);
    check("e0_bank_o", bank_o, 4'd5);
    bus(16'h1010, 1'b0, 8'h00, 1'b0);
    check("e0_s0_adr", rom_adr_o, 15'h1410);
    bus(16'h1410, 1'b0, 8'h00, 1'b0);
    check("e0_s1_adr", rom_adr_o, 15'h0C10);
    bus(16'h1810, 1'b0, 8'h00, 1'b0);
    check("e0_s2_adr", rom_adr_o, 15'h0810);
    bus(16'h1C10, 1'b0, 8'h00, 1'b0);
    check("e0_s3_adr", rom_adr_o, 15'h1C10);

    // ---------------- 3F ----------------
    do_reset(3'd5);
    check("3f_rst_bank", bank_o, 4'd0);
    bus(16'h1234, 1'b0, 8'h00, 1'b0);
    check("3f_rst_adr", rom_adr_o, 15'h0234);

    cpu(16'h003F, 1'b1, 8'h0A);
    check("3f_bank_o", bank_o, 4'hA);
    bus(16'h1234, 1'b0, 8'h00, 1'b0);
    check("3f_low_adr", rom_adr_o, 15'h5234);
    bus(16'h1834, 1'b0, 8'h00, 1'b0);
    check("3f_fixed_adr", rom_adr_o, 15'h7834);

    cpu(16'h003F, 1'b0, 8'h03);
    check("3f_read_ignored", bank_o, 4'hA);
    cpu(16'h0040, 1'b1, 8'h03);
    check("3f_above_range", bank_o, 4'hA);
    cpu(16'h0000, 1'b1, 8'hF6);
    check("3f_low_nibble", bank_o, 4'h6);

    // ---------------- Superchip on F6 ----------------
    sc_en_i = 1'b1;
    do_reset(3'd2);
    check("f6_rst_bank", bank_o, 4'd3);

    bus(16'h1005, 1'b1, 8'h55, 1'b1);
    check("sc_wr_we", sc_we_o, 1'b1);
    check("sc_wr_rd", sc_rd_o, 1'b0);
    check("sc_wr_adr", sc_adr_o, 7'd5);
    tick();
    enable_i = 1'b0;

    bus(16'h1085, 1'b0, 8'h00, 1'b1);
    check("sc_rd_rd", sc_rd_o, 1'b1);
    check("sc_rd_we", sc_we_o, 1'b0);
    check("sc_rd_adr", sc_adr_o, 7'd5);
    tick();
    enable_i = 1'b0;

    bus(16'h1085, 1'b1, 8'h77, 1'b0);
    check("sc_wr_rdwin_we", sc_we_o, 1'b0);
    check("sc_wr_rdwin_rd", sc_rd_o, 1'b0);
    bus(16'h1005, 1'b0, 8'h00, 1'b0);
    check("sc_rd_wrwin", sc_rd_o, 1'b0);
    bus(16'h107F, 1'b1, 8'h00, 1'b0);
    check("sc_wr_top", sc_we_o, 1'b1);
    bus(16'h1080, 1'b1, 8'h00, 1'b0);
    check("sc_wr_past_top", sc_we_o, 1'b0);
    bus(16'h10FF, 1'b0, 8'h00, 1'b0);
    check("sc_rd_top", sc_rd_o, 1'b1);
    bus(16'h1100, 1'b0, 8'h00, 1'b0);
    check("sc_rd_past_top", sc_rd_o, 1'b0);
    bus(16'h0085, 1'b0, 8'h00, 1'b0);
    check("sc_rd_not_cart", sc_rd_o, 1'b0);

    sc_en_i = 1'b0;
    bus(16'h1085, 1'b0, 8'h00, 1'b0);
    check("sc_off_rd", sc_rd_o, 1'b0);
    bus(16'h1005, 1'b1, 8'h00, 1'b0);
    check("sc_off_we", sc_we_o, 1'b0);
    sc_en_i = 1'b1;

    // ---------------- Reset mid-operation (F6) ----------------
    cpu(16'h1FF6, 1'b0, 8'h00);
    check("f6_bank0", bank_o, 4'd0);
    bus(16'h1234, 1'b0, 8'h00, 1'b0);
    check("f6_bank0_adr", rom_adr_o, 15'h0234);

    rst_i = 1'b1;
    bus(16'h1FF7, 1'b0, 8'h00, 1'b1);
    tick();
    rst_i    = 1'b0;
    enable_i = 1'b0;
    check("f6_rst_over_en", bank_o, 4'd3);

    // Superchip is not honoured outside the F-type schemes.
    do_reset(3'd4);
    bus(16'h1085, 1'b0, 8'h00, 1'b0);
    check("sc_e0_rd", sc_rd_o, 1'b0);
    sc_en_i = 1'b0;

    // ---------------- Unused encoding behaves as none ----------------
    do_reset(3'd6);
    check("m6_bank", bank_o, 4'd0);
    bus(16'h1ABC, 1'b0, 8'h00, 1'b0);
    check("m6_adr", rom_adr_o, 15'h0ABC);
    cpu(16'h1FF8, 1'b0, 8'h00);
    bus(16'h1FF8, 1'b0, 8'h00, 1'b0);
    check("m6_no_hot", rom_adr_o, 15'h0FF8);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
